// File: rtl/cpu_controller_if.sv
// cpu_controller_if: instruction fields and control outputs between the controller and the datapath
// master: the controller, which receives opcode/op and drives every control line.
// slave: the datapath/instruction-register side.
interface cpu_controller_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       load_pc;
  logic       reset_pc;
  logic       load_ir;
  logic       load_addr;
  logic       addr_sel;
  logic [1:0] mem_cmd;
  logic       halted;
  modport master (
    input  opcode, op,
    output nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
    output load_pc, reset_pc, load_ir, load_addr, addr_sel, mem_cmd, halted
  );
  modport slave (
    output opcode, op,
    input  nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
    input  load_pc, reset_pc, load_ir, load_addr, addr_sel, mem_cmd, halted
  );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing fetch, decode and execute of a simple 16-bit CPU
// clk: rising-edge clock; reset: synchronous active-high reset.
// bus (master): opcode/op in; register, writeback, ALU, PC/IR, address and memory controls out.
module cpu_controller (
  input  logic              clk,
  input  logic              reset,
  cpu_controller_if.master  bus
);
  typedef enum logic [4:0] {
    RST, IF1, IF2, UPDATE_PC, DECODE, WRITE_IMM, GET_A, GET_B, ALU_MOV, ALU,
    CMP, WRITE_REG, ADDR, LOAD_ADDR, MEM_RD1, MEM_RD2, GET_B_RD, STR_C, MEM_WR, HALT
  } state_t;
  // GET_A, GET_B and LOAD_ADDR are shared between instructions; the class captured
  // in DECODE picks their successor so opcode is never looked at again.
  typedef enum logic [2:0] {K_NONE, K_MOVR, K_ALU, K_CMP, K_LDR, K_STR} kind_t;
  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic [4:0] ins;
  assign ins = {bus.opcode, bus.op};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST;
      kind_q  <= K_NONE;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    case (state_q)
      RST:       state_d = IF1;
      IF1:       state_d = IF2;
      IF2:       state_d = UPDATE_PC;
      UPDATE_PC: state_d = DECODE;
      DECODE: begin
        kind_d  = ins == 5'b11000      ? K_MOVR :
                  ins == 5'b10101      ? K_CMP  :
                  ins[4:2] == 3'b101   ? K_ALU  :
                  ins == 5'b01100      ? K_LDR  :
                  ins == 5'b10000      ? K_STR  : K_NONE;
        state_d = ins[4:2] == 3'b111                               ? HALT      :
                  ins == 5'b11010                                  ? WRITE_IMM :
                  ins inside {5'b10100, 5'b10101, 5'b10110, 5'b01100, 5'b10000} ? GET_A :
                  ins inside {5'b11000, 5'b10111}                  ? GET_B     : IF1;
      end
      GET_A:     state_d = kind_q inside {K_LDR, K_STR} ? ADDR : GET_B;
      GET_B:     state_d = kind_q == K_MOVR ? ALU_MOV : kind_q == K_CMP ? CMP : ALU;
      ALU_MOV:   state_d = WRITE_REG;
      ALU:       state_d = WRITE_REG;
      ADDR:      state_d = LOAD_ADDR;
      LOAD_ADDR: state_d = kind_q == K_LDR ? MEM_RD1 : GET_B_RD;
      MEM_RD1:   state_d = MEM_RD2;
      GET_B_RD:  state_d = STR_C;
      STR_C:     state_d = MEM_WR;
      HALT:      state_d = HALT;
      default:   state_d = IF1;
    endcase
  end
  always_comb begin
    bus.nsel      = state_q inside {WRITE_IMM, GET_A}            ? 3'b100 :
                    state_q inside {WRITE_REG, MEM_RD2, GET_B_RD} ? 3'b010 :
                    state_q == GET_B                              ? 3'b001 : 3'b000;
    bus.vsel      = state_q == MEM_RD2   ? 4'b1000 :
                    state_q == WRITE_IMM ? 4'b0100 :
                    state_q == WRITE_REG ? 4'b0001 : 4'b0000;
    bus.write     = state_q inside {WRITE_IMM, WRITE_REG, MEM_RD2};
    bus.loada     = state_q == GET_A;
    bus.loadb     = state_q inside {GET_B, GET_B_RD};
    bus.loadc     = state_q inside {ALU_MOV, ALU, ADDR, STR_C};
    bus.loads     = state_q == CMP;
    bus.asel      = state_q inside {ALU_MOV, STR_C};
    bus.bsel      = state_q == ADDR;
    bus.load_pc   = state_q inside {RST, UPDATE_PC};
    bus.reset_pc  = state_q == RST;
    bus.load_ir   = state_q == IF2;
    bus.load_addr = state_q == LOAD_ADDR;
    bus.addr_sel  = state_q inside {IF1, IF2};
    bus.mem_cmd   = state_q inside {IF1, IF2, MEM_RD1, MEM_RD2} ? 2'b01 :
                    state_q == MEM_WR                          ? 2'b10 : 2'b00;
    bus.halted    = state_q == HALT;
  end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed, table-driven check of every controller output in every cycle
module tb_cpu_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  cpu_controller_if bus();
  cpu_controller dut (.clk(clk), .reset(reset), .bus(bus.master));
  // word = {nsel, vsel, write,loada,loadb,loadc,loads,asel,bsel,
  //         load_pc,reset_pc,load_ir,load_addr,addr_sel, mem_cmd, halted}
  localparam logic [21:0] Z      = 22'd0;
  localparam logic [21:0] O_RST  = {3'b000, 4'b0000, 7'b0000000, 5'b11000, 2'b00, 1'b0};
  localparam logic [21:0] O_IF1  = {3'b000, 4'b0000, 7'b0000000, 5'b00001, 2'b01, 1'b0};
  localparam logic [21:0] O_IF2  = {3'b000, 4'b0000, 7'b0000000, 5'b00101, 2'b01, 1'b0};
  localparam logic [21:0] O_UPC  = {3'b000, 4'b0000, 7'b0000000, 5'b10000, 2'b00, 1'b0};
  localparam logic [21:0] O_DEC  = Z;
  localparam logic [21:0] O_WIMM = {3'b100, 4'b0100, 7'b1000000, 5'b00000, 2'b00, 1'b0};
  localparam logic [21:0] O_GETA = {3'b100, 4'b0000, 7'b0100000, 5'b00000, 2'b00, 1'b0};
  localparam logic [21:0] O_GETB = {3'b001, 4'b0000, 7'b0010000, 5'b00000, 2'b00, 1'b0};
  localparam logic [21:0] O_AMOV = {3'b000, 4'b0000, 7'b0001010, 5'b00000, 2'b00, 1'b0};
  localparam logic [21:0] O_ALU  = {3'b000, 4'b0000, 7'b0001000, 5'b00000, 2'b00, 1'b0};
  localparam logic [21:0] O_CMP  = {3'b000, 4'b0000, 7'b0000100, 5'b00000, 2'b00, 1'b0};
  localparam logic [21:0] O_WREG = {3'b010, 4'b0001, 7'b1000000, 5'b00000, 2'b00, 1'b0};
  localparam logic [21:0] O_ADDR = {3'b000, 4'b0000, 7'b0001001, 5'b00000, 2'b00, 1'b0};
  localparam logic [21:0] O_LADR = {3'b000, 4'b0000, 7'b0000000, 5'b00010, 2'b00, 1'b0};
  localparam logic [21:0] O_RD1  = {3'b000, 4'b0000, 7'b0000000, 5'b00000, 2'b01, 1'b0};
  localparam logic [21:0] O_RD2  = {3'b010, 4'b1000, 7'b1000000, 5'b00000, 2'b01, 1'b0};
  localparam logic [21:0] O_GBRD = {3'b010, 4'b0000, 7'b0010000, 5'b00000, 2'b00, 1'b0};
  localparam logic [21:0] O_STRC = {3'b000, 4'b0000, 7'b0001010, 5'b00000, 2'b00, 1'b0};
  localparam logic [21:0] O_MWR  = {3'b000, 4'b0000, 7'b0000000, 5'b00000, 2'b10, 1'b0};
  localparam logic [21:0] O_HALT = {3'b000, 4'b0000, 7'b0000000, 5'b00000, 2'b00, 1'b1};
  typedef logic [5:0][21:0] body_t;
  typedef struct {
    string      name;
    logic [2:0] opc;
    logic [1:0] op;
    int         nb;
    body_t      body;
  } vec_t;
  vec_t tbl[10];
  int checks = 0;
  int errors = 0;
  logic [21:0] obs;
  assign obs = {bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads,
                bus.asel, bus.bsel, bus.load_pc, bus.reset_pc, bus.load_ir, bus.load_addr,
                bus.addr_sel, bus.mem_cmd, bus.halted};
  function automatic body_t mkb(input logic [21:0] a, b, c, d, e, f);
    body_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [21:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, obs, exp);
    end
  endtask
  task automatic cyc(input string nm, input logic [21:0] exp, input logic [2:0] oc, input logic [1:0] o);
    @(negedge clk);
    chk(nm, exp);
    bus.opcode = oc;
    bus.op     = o;
  endtask
  // Outside DECODE the instruction fields carry HALT/CMP encodings that must be ignored.
  task automatic run(input vec_t v);
    logic [21:0] exp;
    for (int k = 0; k < 4 + v.nb; k++) begin
      exp = k == 0 ? O_IF1 : k == 1 ? O_IF2 : k == 2 ? O_UPC : k == 3 ? O_DEC : v.body[k-4];
      if (k == 3) cyc($sformatf("%s[%0d]", v.name, k), exp, v.opc, v.op);
      else if (k[0]) cyc($sformatf("%s[%0d]", v.name, k), exp, 3'b111, 2'b11);
      else cyc($sformatf("%s[%0d]", v.name, k), exp, 3'b101, 2'b01);
    end
  endtask
  initial begin
    bus.opcode = 3'b111;
    bus.op     = 2'b11;
    tbl[0] = '{"movi", 3'b110, 2'b10, 1, mkb(O_WIMM, Z, Z, Z, Z, Z)};
    tbl[1] = '{"movr", 3'b110, 2'b00, 3, mkb(O_GETB, O_AMOV, O_WREG, Z, Z, Z)};
    tbl[2] = '{"add",  3'b101, 2'b00, 4, mkb(O_GETA, O_GETB, O_ALU, O_WREG, Z, Z)};
    tbl[3] = '{"and",  3'b101, 2'b10, 4, mkb(O_GETA, O_GETB, O_ALU, O_WREG, Z, Z)};
    tbl[4] = '{"cmp",  3'b101, 2'b01, 3, mkb(O_GETA, O_GETB, O_CMP, Z, Z, Z)};
    tbl[5] = '{"mvn",  3'b101, 2'b11, 3, mkb(O_GETB, O_ALU, O_WREG, Z, Z, Z)};
    tbl[6] = '{"ldr",  3'b011, 2'b00, 5, mkb(O_GETA, O_ADDR, O_LADR, O_RD1, O_RD2, Z)};
    tbl[7] = '{"str",  3'b100, 2'b00, 6, mkb(O_GETA, O_ADDR, O_LADR, O_GBRD, O_STRC, O_MWR)};
    tbl[8] = '{"und1", 3'b110, 2'b01, 0, mkb(Z, Z, Z, Z, Z, Z)};
    tbl[9] = '{"und2", 3'b011, 2'b10, 0, mkb(Z, Z, Z, Z, Z, Z)};
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", O_RST);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) run(tbl[i]);
    // reset in LDR MEM_RD1 aborts before MEM_RD2 can write
    cyc("ab_if1", O_IF1, 3'b111, 2'b11);
    cyc("ab_if2", O_IF2, 3'b111, 2'b11);
    cyc("ab_upc", O_UPC, 3'b111, 2'b11);
    cyc("ab_dec", O_DEC, 3'b011, 2'b00);
    cyc("ab_geta", O_GETA, 3'b111, 2'b11);
    cyc("ab_addr", O_ADDR, 3'b111, 2'b11);
    cyc("ab_ladr", O_LADR, 3'b111, 2'b11);
    cyc("ab_rd1", O_RD1, 3'b111, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    chk("ab_rst", O_RST);
    reset = 1'b0;
    cyc("h_if1", O_IF1, 3'b000, 2'b00);
    cyc("h_if2", O_IF2, 3'b000, 2'b00);
    cyc("h_upc", O_UPC, 3'b000, 2'b00);
    cyc("h_dec", O_DEC, 3'b111, 2'b01);
    for (int i = 0; i < 20; i++) begin
      if (i[0]) cyc("halt", O_HALT, 3'b110, 2'b10);
      else cyc("halt", O_HALT, 3'b011, 2'b00);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("h_rst", O_RST);
    reset = 1'b0;
    @(negedge clk);
    chk("h_if1_after", O_IF1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 No parameters; all encodings below are fixed.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  3  instruction bits [15:13] from instruction register.
REQ-005 op  input  2  instruction bits [12:11] from instruction register.
REQ-006 nsel  output  3  one-hot register select: 3'b100=Rn, 3'b010=Rd, 3'b001=Rm, 3'b000=none.
REQ-007 vsel  output  4  one-hot writeback select: 4'b1000=mdata, 4'b0100=sximm8, 4'b0010=PC, 4'b0001=datapath_out.
REQ-008 write, loada, loadb, loadc, loads, asel, bsel  output  1 each  datapath controls; bsel=1 selects sximm5.
REQ-009 load_pc, reset_pc, load_ir, load_addr, addr_sel  output  1 each  fetch/address controls; addr_sel=1 selects PC, 0 selects data address.
REQ-010 mem_cmd  output  2  2'b00=NONE, 2'b01=READ, 2'b10=WRITE.
REQ-011 halted  output  1  high only in HALT.

Function
REQ-012 Moore FSM; every output is a function of the current state only.
REQ-013 Any output not listed for a state is 0; nsel=3'b000, vsel=4'b0000, mem_cmd=NONE.
REQ-014 RST: reset_pc=1, load_pc=1; next IF1.
REQ-015 IF1: addr_sel=1, mem_cmd=READ; next IF2.
REQ-016 IF2: addr_sel=1, mem_cmd=READ, load_ir=1; next UPDATE_PC.
REQ-017 UPDATE_PC: load_pc=1, reset_pc=0; next DECODE.
REQ-018 DECODE: no outputs; branches on {opcode,op} per REQ-019..REQ-025.
REQ-019 MOV imm (110,10): WRITE_IMM (nsel=Rn, vsel=sximm8, write=1); then IF1.
REQ-020 MOV reg (110,00): GET_B (nsel=Rm, loadb=1), ALU_MOV (asel=1, bsel=0, loadc=1), WRITE_REG (nsel=Rd, vsel=datapath_out, write=1); then IF1.
REQ-021 ADD/AND (101,00/10): GET_A (nsel=Rn, loada=1), GET_B, ALU (asel=0, bsel=0, loadc=1), WRITE_REG; then IF1.
REQ-022 CMP (101,01): GET_A, GET_B, CMP (asel=0, bsel=0, loads=1, loadc=0); then IF1; no register write.
REQ-023 MVN (101,11): GET_B, ALU, WRITE_REG; then IF1; GET_A skipped.
REQ-024 LDR (011,00): GET_A, ADDR (asel=0, bsel=1, loadc=1), LOAD_ADDR (load_addr=1), MEM_RD1 (addr_sel=0, mem_cmd=READ), MEM_RD2 (addr_sel=0, mem_cmd=READ, nsel=Rd, vsel=mdata, write=1); then IF1.
REQ-025 STR (100,00): GET_A, ADDR, LOAD_ADDR, GET_B_RD (nsel=Rd, loadb=1), STR_C (asel=1, bsel=0, loadc=1), MEM_WR (addr_sel=0, mem_cmd=WRITE); then IF1.
REQ-026 HALT (111,xx): enter HALT; halted=1, all other outputs 0; remain until reset.
REQ-027 Any other {opcode,op} in DECODE: next IF1, no datapath or memory side effects.
REQ-028 Instruction latency, IF1 to next IF1: MOV imm 5, MOV reg 7, ADD/AND 8, CMP 7, MVN 7, LDR 9, STR 10 cycles.
REQ-029 write and mem_cmd=WRITE are never asserted in the same cycle.
REQ-030 load_ir is asserted only in IF2; load_pc only in RST and UPDATE_PC.
REQ-031 opcode/op are sampled only in DECODE; changes in other states have no effect.

Reset
REQ-032 reset=1 at a rising edge forces next state RST from any state, including mid-instruction and HALT; no partial instruction completes.
REQ-033 While reset is held, the FSM stays in RST with reset_pc=1, load_pc=1, and all other outputs 0.
REQ-034 First edge with reset=0 moves RST to IF1.

Verification
REQ-035 Reset, then MOV imm (110,10) -> states RST, IF1, IF2, UPDATE_PC, DECODE, WRITE_IMM; WRITE_IMM has nsel=100, vsel=0100, write=1; IF1 follows.
REQ-036 ADD (101,00) -> GET_A nsel=100 loada=1; GET_B nsel=001 loadb=1; ALU loadc=1; WRITE_REG nsel=010 vsel=0001 write=1; 8 cycles IF1 to IF1.
REQ-037 CMP (101,01) -> loads=1 for exactly one cycle; write=0 throughout; next IF1 after 7 cycles.
REQ-038 LDR then STR -> LDR MEM_RD2 has vsel=1000, write=1, mem_cmd=01, addr_sel=0; STR MEM_WR has mem_cmd=10, write=0; 9 and 10 cycles respectively.
REQ-039 HALT (111) -> halted=1 held for 20 cycles with opcode toggling; reset=1 for one edge -> RST, then IF1.
REQ-040 reset asserted during LDR MEM_RD1 -> next state RST; no write and no mem_cmd=READ in that cycle.
